hdmi_colorbar_gen: RTL

- Video timing generator and colour-bar pattern source that sits directly upstream of the per-channel TMDS encoders.
- Generates the 640x480@60 raster (25.2 MHz pixel clock): hsync (encoder c0), vsync (encoder c1), de, plus 8-bit red/green/blue.
- Each colour channel feeds one encoder's data_in.
- All outputs are registered and mutually aligned.

---
 rtl/hdmi_colorbar_gen_if.sv | 21 ++
 rtl/hdmi_colorbar_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_colorbar_gen_if.sv
// Video output bundle of hdmi_colorbar_gen: sync, data enable, pixel position and RGB.
// The master drives the raster; slaves (TMDS encoders, monitors) observe it.
interface hdmi_colorbar_gen_if;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       frame_start;

  modport master (
    output hsync, vsync, de, pix_x, pix_y, red, green, blue, frame_start
  );

  modport slave (
    input hsync, vsync, de, pix_x, pix_y, red, green, blue, frame_start
  );
endinterface

// File: rtl/hdmi_colorbar_gen.sv
// 640x480@60 raster timing generator with an 8-bar colour pattern, all outputs registered.
// Optional macro COLORBAR_SCROLL_EN rotates the bars left by one every SCROLL_FRAMES frames.
module hdmi_colorbar_gen #(
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned H_VALID       = 640,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 33,
  parameter int unsigned V_VALID       = 480,
  parameter int unsigned V_FRONT       = 10,
  parameter int unsigned SCROLL_FRAMES = 60
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  hdmi_colorbar_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int unsigned BAR_W   = H_VALID / 8;
  localparam int unsigned CW      = 12;

  localparam logic [CW-1:0] HMax       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VMax       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HSyncEnd   = CW'(H_SYNC);
  localparam logic [CW-1:0] VSyncEnd   = CW'(V_SYNC);
  localparam logic [CW-1:0] HActStart  = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] HActEnd    = CW'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [CW-1:0] VActStart  = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] VActEnd    = CW'(V_SYNC + V_BACK + V_VALID - 1);
  localparam logic [CW-1:0] BarPosMax  = CW'(BAR_W - 1);

  if ((H_VALID % 8) != 0 || H_VALID == 0 || SCROLL_FRAMES == 0) begin : g_bad_cfg
    $error("hdmi_colorbar_gen: H_VALID must be a non-zero multiple of 8, SCROLL_FRAMES > 0");
  end

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [CW-1:0] bar_pos_q, bar_pos_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [2:0]    start_idx;

  logic          h_wrap, v_wrap;
  logic          h_act, v_act, active, line_start;
  logic [CW-1:0] cur_pos;
  logic [2:0]    cur_idx;
  logic [23:0]   bar_rgb;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [9:0]    pix_x_q, pix_x_d;
  logic [9:0]    pix_y_q, pix_y_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          frame_start_q, frame_start_d;

  // Raster counters
  always_comb begin
    h_wrap  = (h_cnt_q == HMax);
    v_wrap  = (v_cnt_q == VMax);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Bar tracking: the state holds the bar of the current pixel, except on the first active
  // column where the line restarts from start_idx.
  always_comb begin
    h_act      = (h_cnt_q >= HActStart) && (h_cnt_q <= HActEnd);
    v_act      = (v_cnt_q >= VActStart) && (v_cnt_q <= VActEnd);
    active     = h_act && v_act;
    line_start = (h_cnt_q == HActStart);
    cur_idx    = line_start ? start_idx : bar_idx_q;
    cur_pos    = line_start ? '0 : bar_pos_q;
    bar_idx_d  = bar_idx_q;
    bar_pos_d  = bar_pos_q;
    if (active) begin
      if (cur_pos == BarPosMax) begin
        bar_pos_d = '0;
        bar_idx_d = cur_idx + 3'd1;
      end else begin
        bar_pos_d = cur_pos + 1'b1;
        bar_idx_d = cur_idx;
      end
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (cur_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase
  end

  // Every output is a function of the current counter pair, registered once
  always_comb begin
    hsync_d       = (h_cnt_q < HSyncEnd);
    vsync_d       = (v_cnt_q < VSyncEnd);
    de_d          = active;
    pix_x_d       = '0;
    pix_y_d       = '0;
    rgb_d         = '0;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    if (active) begin
      pix_x_d = 10'(h_cnt_q - HActStart);
      pix_y_d = 10'(v_cnt_q - VActStart);
      rgb_d   = bar_rgb;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_pos_q     <= '0;
      bar_idx_q     <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_pos_q     <= bar_pos_d;
      bar_idx_q     <= bar_idx_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef COLORBAR_SCROLL_EN
  localparam int unsigned FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FW-1:0] FrameMax = FW'(SCROLL_FRAMES - 1);

  logic          frame_end;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]    bar_offset_q, bar_offset_d;

  // Advancing on the last raster position keeps the offset stable for the whole next frame
  always_comb begin
    frame_end    = h_wrap && v_wrap;
    frame_cnt_d  = frame_cnt_q;
    bar_offset_d = bar_offset_q;
    if (frame_end) begin
      if (frame_cnt_q == FrameMax) begin
        frame_cnt_d  = '0;
        bar_offset_d = bar_offset_q + 3'd1;
      end else begin
        frame_cnt_d  = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt_q  <= '0;
      bar_offset_q <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      bar_offset_q <= bar_offset_d;
    end
  end

  assign start_idx = bar_offset_q;
`else
  assign start_idx = 3'd0;
`endif

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.pix_x       = pix_x_q;
  assign vid.pix_y       = pix_y_q;
  assign vid.red         = rgb_q[23:16];
  assign vid.green       = rgb_q[15:8];
  assign vid.blue        = rgb_q[7:0];
  assign vid.frame_start = frame_start_q;

endmodule
